// File: rtl/spi_sampler_pkg.sv
// Shared types, constants and helpers for the SPI slave frame sampler.
package spi_sampler_pkg;

  // Flops in each pin synchronizer.
  localparam int SYNC_DEPTH = 2;

  // Minimum pclk periods per sclk period for reliable edge detection.
  localparam int MIN_CLK_RATIO = 4;

  // Capture FSM: IDLE waits for chip select, SHIFT collects characters.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Sampling edge is rising when CPOL equals CPHA, falling otherwise.
  function automatic logic sample_rising(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_sync_2ff.sv
// Multi-flop synchronizer for one asynchronous pin, with a configurable reset value.
module spi_sync_2ff
  import spi_sampler_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] sync_q;

  // Shift the pin through the synchronizer chain; the oldest flop is the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_DEPTH{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/spi_slave_frame_sampler.sv
// Samples raw SPI pins into the pclk domain, assembles MOSI/MISO characters and
// offers each completed pair to the downstream monitor.
//
// Handshake: frame_valid rises when a pair is loaded and stays high, with
// mosi_data/miso_data stable, until a cycle with frame_valid & frame_ready.
// A character completing while the held pair is not being accepted is dropped
// and sets the sticky overflow flag.
module spi_slave_frame_sampler
  import spi_sampler_pkg::*;
#(
  parameter int CHAR_LENGTH = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1
) (
  input  logic                   pclk,
  input  logic                   areset,
  input  logic                   sclk,
  input  logic                   cs_n,
  input  logic                   mosi,
  input  logic                   miso,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [CHAR_LENGTH-1:0] mosi_data,
  output logic [CHAR_LENGTH-1:0] miso_data,
  output logic                   frame_short,
  output logic                   overflow,
  output logic                   busy
);

  localparam int               CNT_W  = $clog2(CHAR_LENGTH);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(CHAR_LENGTH - 1);
  localparam logic             CPOL_B = (CPOL != 0);
  localparam logic             CPHA_B = (CPHA != 0);
  localparam logic             RISE   = sample_rising(CPOL_B, CPHA_B);

  logic sclk_s, cs_s, mosi_s, miso_s;
  logic sclk_d;
  logic sample_en;
  logic char_done;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [CHAR_LENGTH-1:0] mosi_sr, miso_sr;
  logic [CHAR_LENGTH-1:0] mosi_next, miso_next;

  spi_sync_2ff #(.RST_VAL(CPOL_B)) u_sync_sclk (.clk(pclk), .rst(areset), .d(sclk), .q(sclk_s));
  spi_sync_2ff #(.RST_VAL(1'b1))   u_sync_cs   (.clk(pclk), .rst(areset), .d(cs_n), .q(cs_s));
  spi_sync_2ff #(.RST_VAL(1'b0))   u_sync_mosi (.clk(pclk), .rst(areset), .d(mosi), .q(mosi_s));
  spi_sync_2ff #(.RST_VAL(1'b0))   u_sync_miso (.clk(pclk), .rst(areset), .d(miso), .q(miso_s));

  // Delay the synchronized sclk by one cycle to expose its edges.
  always_ff @(posedge pclk) begin
    if (areset) begin
      sclk_d <= CPOL_B;
    end else begin
      sclk_d <= sclk_s;
    end
  end

  assign sample_en = !cs_s && (RISE ? (sclk_s && !sclk_d) : (!sclk_s && sclk_d));

  // Next shift-register contents with the current synchronized bits inserted.
  always_comb begin
    mosi_next = '0;
    miso_next = '0;
    if (MSB_FIRST != 0) begin
      mosi_next = {mosi_sr[CHAR_LENGTH-2:0], mosi_s};
      miso_next = {miso_sr[CHAR_LENGTH-2:0], miso_s};
    end else begin
      mosi_next = {mosi_s, mosi_sr[CHAR_LENGTH-1:1]};
      miso_next = {miso_s, miso_sr[CHAR_LENGTH-1:1]};
    end
  end

  assign char_done = (state == SHIFT) && sample_en && (bit_cnt == LAST);

  // Capture FSM: shift on sampling edges, detect chip-select release.
  always_ff @(posedge pclk) begin
    if (areset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      mosi_sr     <= '0;
      miso_sr     <= '0;
      frame_short <= 1'b0;
    end else begin
      frame_short <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!cs_s) state <= SHIFT;
        end
        SHIFT: begin
          if (cs_s) begin
            state   <= IDLE;
            bit_cnt <= '0;
            if (bit_cnt != '0) frame_short <= 1'b1;
          end else if (sample_en) begin
            mosi_sr <= mosi_next;
            miso_sr <= miso_next;
            bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register toward the monitor, with drop-on-full overflow tracking.
  always_ff @(posedge pclk) begin
    if (areset) begin
      frame_valid <= 1'b0;
      mosi_data   <= '0;
      miso_data   <= '0;
      overflow    <= 1'b0;
    end else if (char_done) begin
      if (!frame_valid || frame_ready) begin
        frame_valid <= 1'b1;
        mosi_data   <= mosi_next;
        miso_data   <= miso_next;
      end else begin
        overflow <= 1'b1;
      end
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_slave_frame_sampler.sv
// Bench for spi_slave_frame_sampler: five instances cover the four SPI modes
// plus LSB-first capture; one acts at a time while the others stay deselected.
module tb_spi_slave_frame_sampler;

  localparam int N = 5;
  localparam int H = 4;  // sclk half period in pclk cycles
  localparam int CPOL_T [N] = '{0, 0, 1, 1, 0};
  localparam int CPHA_T [N] = '{0, 1, 0, 1, 0};
  localparam int MSBF_T [N] = '{1, 1, 1, 1, 0};

  // Clock and reset
  logic pclk = 1'b0;
  logic areset = 1'b1;
  always #5 pclk = ~pclk;

  logic       sclk_a [N];
  logic       cs_a   [N];
  logic       mosi_a [N];
  logic       miso_a [N];
  logic       ready_a[N];
  logic       fv_a   [N];
  logic [7:0] md_a   [N];
  logic [7:0] sd_a   [N];
  logic       fs_a   [N];
  logic       ov_a   [N];
  logic       busy_a [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_slave_frame_sampler #(
      .CHAR_LENGTH(8), .CPOL(CPOL_T[g]), .CPHA(CPHA_T[g]), .MSB_FIRST(MSBF_T[g])
    ) u_dut (
      .pclk(pclk), .areset(areset), .sclk(sclk_a[g]), .cs_n(cs_a[g]),
      .mosi(mosi_a[g]), .miso(miso_a[g]), .frame_valid(fv_a[g]),
      .frame_ready(ready_a[g]), .mosi_data(md_a[g]), .miso_data(sd_a[g]),
      .frame_short(fs_a[g]), .overflow(ov_a[g]), .busy(busy_a[g])
    );
  end

  // Scoreboard state
  logic [15:0] exp_q[$];
  logic [15:0] act_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int short_cnt = 0;

  // Monitor: record accepted pairs and frame_short pulses.
  always @(negedge pclk) begin
    for (int i = 0; i < N; i++) begin
      if (fv_a[i] === 1'b1 && ready_a[i] === 1'b1) act_q.push_back({md_a[i], sd_a[i]});
      if (fs_a[i] === 1'b1) begin
        short_cnt++;
        n_cmp++;
        if (busy_a[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_with_short[%0d]: got %b want 0", i, busy_a[i]);
        end
      end
    end
  end

  // Driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic set_ready(input int idx, input logic v);
    @(posedge pclk);
    #1 ready_a[idx] = v;
  endtask

  task automatic reset_dut();
    @(negedge pclk);
    areset = 1'b1;
    wait_cyc(2);
    areset = 1'b0;
    wait_cyc(2);
  endtask

  task automatic cs_assert(input int idx);
    @(negedge pclk);
    cs_a[idx] = 1'b0;
    wait_cyc(H);
  endtask

  task automatic cs_release(input int idx);
    wait_cyc(H);
    cs_a[idx] = 1'b1;
    wait_cyc(6);
  endtask

  // One bit; optionally pulse frame_ready in the cycle the sampling edge is consumed.
  task automatic send_bit(input int idx, input logic m, input logic s, input bit pulse);
    if (CPHA_T[idx] == 0) begin
      mosi_a[idx] = m; miso_a[idx] = s;
      wait_cyc(H);
      sclk_a[idx] = ~sclk_a[idx];
    end else begin
      sclk_a[idx] = ~sclk_a[idx];
      mosi_a[idx] = m; miso_a[idx] = s;
      wait_cyc(H);
      sclk_a[idx] = ~sclk_a[idx];
    end
    if (pulse) begin
      @(posedge pclk);
      @(posedge pclk);
      #1 ready_a[idx] = 1'b1;
      @(posedge pclk);
      #1 ready_a[idx] = 1'b0;
      wait_cyc(2);
    end else begin
      wait_cyc(H);
    end
    if (CPHA_T[idx] == 0) sclk_a[idx] = ~sclk_a[idx];
  endtask

  task automatic send_char(input int idx, input logic [7:0] m, input logic [7:0] s,
                           input int nbits, input bit pulse_last);
    for (int b = 0; b < nbits; b++) begin
      int pos;
      pos = (MSBF_T[idx] != 0) ? 7 - b : b;
      send_bit(idx, m[pos], s[pos], pulse_last && (b == 7));
    end
  endtask

  // Compare every recorded pair against the expected queue.
  task automatic drain_compare(input string name);
    n_cmp++;
    if (act_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d want %0d", name, act_q.size(), exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] a, e;
      a = act_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s_pair: got %h want %h", name, a, e);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  // Tests
  task automatic test_reset();
    reset_dut();
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if ({fv_a[i], fs_a[i], ov_a[i], busy_a[i], md_a[i], sd_a[i]} !== 20'h0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got v%b s%b o%b b%b %h %h want all 0",
                 i, fv_a[i], fs_a[i], ov_a[i], busy_a[i], md_a[i], sd_a[i]);
      end
    end
  endtask

  task automatic test_mode(input int idx);
    logic [7:0] m, s;
    act_q.delete(); exp_q.delete(); short_cnt = 0;
    set_ready(idx, 1'b1);
    cs_assert(idx);
    send_char(idx, 8'hA5, 8'h3C, 8, 1'b0);
    exp_q.push_back({8'hA5, 8'h3C});
    for (int k = 0; k < 2; k++) begin
      m = 8'($urandom_range(0, 255)); s = 8'($urandom_range(0, 255));
      send_char(idx, m, s, 8, 1'b0);
      exp_q.push_back({m, s});
    end
    cs_release(idx);
    drain_compare($sformatf("mode%0d", idx));
    n_cmp++;
    if (short_cnt !== 0 || ov_a[idx] !== 1'b0 || fv_a[idx] !== 1'b0) begin
      n_fail++;
      $display("FAIL mode%0d_flags: got short %0d ovf %b valid %b want 0 0 0",
               idx, short_cnt, ov_a[idx], fv_a[idx]);
    end
  endtask

  task automatic test_random();
    logic [7:0] m, s;
    act_q.delete(); exp_q.delete();
    cs_assert(0);
    for (int k = 0; k < 6; k++) begin
      m = 8'($urandom); s = 8'($urandom);
      send_char(0, m, s, 8, 1'b0);
      exp_q.push_back({m, s});
    end
    cs_release(0);
    drain_compare("random");
  endtask

  task automatic test_back_to_back();
    logic [7:0] s0;
    s0 = 8'($urandom);
    reset_dut();
    act_q.delete();
    set_ready(0, 1'b0);
    cs_assert(0);
    send_char(0, 8'h01, s0, 8, 1'b0);
    send_char(0, 8'h02, 8'($urandom), 8, 1'b0);
    send_char(0, 8'h03, 8'($urandom), 8, 1'b0);
    cs_release(0);
    n_cmp++;
    if ({fv_a[0], ov_a[0], md_a[0], sd_a[0]} !== {1'b1, 1'b1, 8'h01, s0}) begin
      n_fail++;
      $display("FAIL b2b_held: got v%b o%b %h %h want v1 o1 01 %h",
               fv_a[0], ov_a[0], md_a[0], sd_a[0], s0);
    end
    n_cmp++;
    if (act_q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_no_accept: got %0d want 0", act_q.size());
    end
    set_ready(0, 1'b1);
    set_ready(0, 1'b0);
    wait_cyc(1);
    exp_q.delete();
    exp_q.push_back({8'h01, s0});
    drain_compare("b2b_accept");
    n_cmp++;
    if ({fv_a[0], ov_a[0], md_a[0]} !== {1'b0, 1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL b2b_after: got v%b o%b %h want v0 o1 01", fv_a[0], ov_a[0], md_a[0]);
    end
  endtask

  task automatic test_ready_pulse();
    logic [7:0] s0, s1;
    s0 = 8'($urandom); s1 = 8'($urandom);
    reset_dut();
    act_q.delete();
    cs_assert(0);
    send_char(0, 8'h01, s0, 8, 1'b0);
    send_char(0, 8'h02, s1, 8, 1'b1);
    n_cmp++;
    if ({fv_a[0], ov_a[0], md_a[0], sd_a[0]} !== {1'b1, 1'b0, 8'h02, s1}) begin
      n_fail++;
      $display("FAIL pulse_loaded: got v%b o%b %h %h want v1 o0 02 %h",
               fv_a[0], ov_a[0], md_a[0], sd_a[0], s1);
    end
    exp_q.delete();
    exp_q.push_back({8'h01, s0});
    drain_compare("pulse_accept");
    send_char(0, 8'h03, 8'($urandom), 8, 1'b0);
    cs_release(0);
    n_cmp++;
    if ({ov_a[0], md_a[0], sd_a[0]} !== {1'b1, 8'h02, s1}) begin
      n_fail++;
      $display("FAIL pulse_drop3: got o%b %h %h want o1 02 %h", ov_a[0], md_a[0], sd_a[0], s1);
    end
  endtask

  task automatic test_short_frame();
    logic [7:0] s;
    set_ready(0, 1'b1);
    wait_cyc(2);
    act_q.delete(); exp_q.delete(); short_cnt = 0;
    cs_assert(0);
    send_char(0, 8'($urandom), 8'($urandom), 5, 1'b0);
    cs_release(0);
    n_cmp++;
    if (short_cnt !== 1 || act_q.size() !== 0 || busy_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL short_pulse: got short %0d frames %0d busy %b want 1 0 0",
               short_cnt, act_q.size(), busy_a[0]);
    end
    s = 8'($urandom);
    cs_assert(0);
    send_char(0, 8'hC3, s, 8, 1'b0);
    cs_release(0);
    exp_q.push_back({8'hC3, s});
    drain_compare("short_next");
    n_cmp++;
    if (short_cnt !== 1) begin
      n_fail++;
      $display("FAIL short_once: got %0d want 1", short_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s;
    short_cnt = 0;
    cs_assert(0);
    send_char(0, 8'hFF, 8'hFF, 4, 1'b0);
    areset = 1'b1;
    wait_cyc(1);
    n_cmp++;
    if ({fv_a[0], fs_a[0], ov_a[0], busy_a[0], md_a[0], sd_a[0]} !== 20'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v%b s%b o%b b%b %h %h want all 0",
               fv_a[0], fs_a[0], ov_a[0], busy_a[0], md_a[0], sd_a[0]);
    end
    areset = 1'b0;
    cs_release(0);
    act_q.delete(); exp_q.delete();
    s = 8'($urandom);
    cs_assert(0);
    send_char(0, 8'h5A, s, 8, 1'b0);
    cs_release(0);
    exp_q.push_back({8'h5A, s});
    drain_compare("midreset_next");
    n_cmp++;
    if (short_cnt !== 0 || ov_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_flags: got short %0d ovf %b want 0 0", short_cnt, ov_a[0]);
    end
  endtask

  // Sequence and final report
  initial begin
    for (int i = 0; i < N; i++) begin
      sclk_a[i] = (CPOL_T[i] != 0);
      cs_a[i] = 1'b1; mosi_a[i] = 1'b0; miso_a[i] = 1'b0; ready_a[i] = 1'b0;
    end
    test_reset();
    for (int i = 0; i < N; i++) test_mode(i);
    test_random();
    test_back_to_back();
    test_ready_pulse();
    test_short_frame();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
